// File: rtl/fan_pwm_ctrl_if.sv
// fan_pwm_ctrl_if: counter/request inputs and PWM/status outputs of the fan controller.
interface fan_pwm_ctrl_if;
    logic [9:0] counter;
    logic       speed_up;
    logic       speed_down;
    logic       stop;
    logic       pwm;
    logic [1:0] level;
    logic [9:0] duty;
    logic       ramping;
    modport master (output counter, speed_up, speed_down, stop, input pwm, level, duty, ramping);
    modport slave  (input counter, speed_up, speed_down, stop, output pwm, level, duty, ramping);
endinterface

// File: rtl/fan_pwm_ctrl.sv
// fan_pwm_ctrl: 4-level fan PWM with duty ramping at period boundaries.
// FAN_SOFTSTART_EN: ramp duty by RAMP_STEP per boundary instead of jumping to target.
module fan_pwm_ctrl #(
    parameter int PERIOD_MAX = 999,
    parameter int RAMP_STEP  = 50
) (
    input  logic           i_clk,
    input  logic           i_reset,
    fan_pwm_ctrl_if.slave  bus
);
`ifdef FAN_SOFTSTART_EN
    localparam logic [10:0] STEP = 11'(RAMP_STEP);
`else
    // A step wider than any duty distance makes the ramp a single jump.
    localparam logic [10:0] STEP = 11'(RAMP_STEP > PERIOD_MAX ? RAMP_STEP : PERIOD_MAX + 1);
`endif
    typedef enum logic [1:0] {IDLE, RAMP, RUN} state_t;
    state_t      state, state_n;
    logic [1:0]  level, level_n;
    logic [9:0]  duty, duty_n, target, target_n;
    logic [10:0] up_sum, dn_lim;
    logic        armed, boundary, pwm;

    assign boundary = bus.counter == 10'(PERIOD_MAX);
    assign target   = 10'(level) * 10'd300;
    assign target_n = 10'(level_n) * 10'd300;
    assign up_sum   = {1'b0, duty} + STEP;
    assign dn_lim   = {1'b0, target} + STEP;

    always_comb begin
        level_n = level;
        if (bus.stop)
            level_n = 2'd0;
        else if (bus.speed_up && !bus.speed_down && level != 2'd3)
            level_n = level + 2'd1;
        else if (bus.speed_down && !bus.speed_up && level != 2'd0)
            level_n = level - 2'd1;
    end

    // Clamp both directions so duty lands exactly on target.
    always_comb begin
        duty_n = duty;
        if (boundary && duty < target)
            duty_n = up_sum >= {1'b0, target} ? target : up_sum[9:0];
        else if (boundary && duty > target)
            duty_n = {1'b0, duty} <= dn_lim ? target : 10'({1'b0, duty} - STEP);
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (target_n != 10'd0) state_n = RAMP;
            RAMP:    if (duty_n == target_n) state_n = duty_n == 10'd0 ? IDLE : RUN;
            RUN:     if (target_n != duty_n) state_n = RAMP;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
            level <= 2'd0;
            duty  <= 10'd0;
            armed <= 1'b0;
            pwm   <= 1'b0;
        end else begin
            state <= state_n;
            level <= level_n;
            duty  <= duty_n;
            armed <= armed | boundary;
            pwm   <= armed && bus.counter <= 10'(PERIOD_MAX) && bus.counter < duty;
        end
    end

    assign bus.pwm     = pwm;
    assign bus.level   = level;
    assign bus.duty    = duty;
    assign bus.ramping = state == RAMP;
endmodule

// File: tb/tb_fan_pwm_ctrl.sv
// tb_fan_pwm_ctrl: directed checks of levels, ramping, PWM high counts and reset.
module tb_fan_pwm_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;
    int   n;
    fan_pwm_ctrl_if bus ();
    fan_pwm_ctrl dut (.i_clk(clk), .i_reset(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Counter values above 999 are held so out-of-range input can be applied.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (bus.counter <= 10'd999) bus.counter = bus.counter == 10'd999 ? 10'd0 : bus.counter + 10'd1;
    endtask

    task automatic pulse(input logic u, input logic d, input logic s);
        bus.speed_up = u;
        bus.speed_down = d;
        bus.stop = s;
        cyc();
        bus.speed_up = 1'b0;
        bus.speed_down = 1'b0;
        bus.stop = 1'b0;
    endtask

    task automatic to_boundary();
        while (bus.counter != 10'd999) cyc();
        cyc();
    endtask

    task automatic count_period(output int highs);
        highs = 0;
        repeat (1000) begin
            cyc();
            highs += int'(bus.pwm);
        end
    endtask

    task automatic settle();
        for (int i = 0; i < 20 && bus.ramping; i++) to_boundary();
    endtask

    initial begin
        bus.counter = 10'd0;
        bus.speed_up = 1'b0;
        bus.speed_down = 1'b0;
        bus.stop = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_pwm", 32'(bus.pwm), 0);
        chk("rst_level", 32'(bus.level), 0);
        chk("rst_duty", 32'(bus.duty), 0);
        chk("rst_ramping", 32'(bus.ramping), 0);
        repeat (2) @(posedge clk);
        #1;
        bus.counter = 10'd500;
        rst = 1'b0;

        pulse(1'b1, 1'b0, 1'b0);
        chk("up_level1", 32'(bus.level), 1);
        chk("up_ramping", 32'(bus.ramping), 1);
        chk("up_duty_hold", 32'(bus.duty), 0);
`ifdef FAN_SOFTSTART_EN
        for (int i = 1; i <= 6; i++) begin
            to_boundary();
            chk("soft_duty", 32'(bus.duty), 32'(50 * i));
            chk("soft_ramping", 32'(bus.ramping), (i < 6) ? 1 : 0);
        end
`else
        to_boundary();
        chk("jump_duty", 32'(bus.duty), 300);
        chk("jump_ramping", 32'(bus.ramping), 0);
`endif
        count_period(n);
        chk("highs_300", 32'(n), 300);

        pulse(1'b1, 1'b0, 1'b0);
        chk("up_level2", 32'(bus.level), 2);
        pulse(1'b1, 1'b0, 1'b0);
        chk("up_level3", 32'(bus.level), 3);
        pulse(1'b1, 1'b0, 1'b0);
        chk("up_sat3", 32'(bus.level), 3);
        settle();
        chk("run900_duty", 32'(bus.duty), 900);
        chk("run900_ramping", 32'(bus.ramping), 0);
        count_period(n);
        chk("highs_900", 32'(n), 900);

        pulse(1'b0, 1'b0, 1'b1);
        chk("stop_level", 32'(bus.level), 0);
        chk("stop_ramping", 32'(bus.ramping), 1);
        bus.counter = 10'd1023;
        repeat (3) cyc();
        chk("oor_duty", 32'(bus.duty), 900);
        chk("oor_pwm", 32'(bus.pwm), 0);
        bus.counter = 10'd0;
        settle();
        chk("idle_duty", 32'(bus.duty), 0);
        chk("idle_ramping", 32'(bus.ramping), 0);
        count_period(n);
        chk("highs_0", 32'(n), 0);
        pulse(1'b0, 1'b1, 1'b0);
        chk("down_sat0", 32'(bus.level), 0);

        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        chk("level2_a", 32'(bus.level), 2);
        pulse(1'b1, 1'b0, 1'b1);
        chk("stop_prio", 32'(bus.level), 0);
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b1, 1'b0);
        chk("up_down_hold", 32'(bus.level), 2);
`ifdef FAN_SOFTSTART_EN
        repeat (4) to_boundary();
        chk("redir_start", 32'(bus.duty), 200);
        pulse(1'b0, 1'b1, 1'b0);
        chk("redir_level", 32'(bus.level), 1);
        to_boundary();
        chk("redir_250", 32'(bus.duty), 250);
        chk("redir_ramp", 32'(bus.ramping), 1);
        to_boundary();
        chk("redir_300", 32'(bus.duty), 300);
        chk("redir_run", 32'(bus.ramping), 0);
        pulse(1'b1, 1'b0, 1'b0);
`endif
        settle();
        chk("run600_duty", 32'(bus.duty), 600);

        repeat (5) cyc();
        chk("pre_rst_pwm", 32'(bus.pwm), 1);
        rst = 1'b1;
        #1;
        chk("arst_pwm", 32'(bus.pwm), 0);
        chk("arst_duty", 32'(bus.duty), 0);
        chk("arst_level", 32'(bus.level), 0);
        chk("arst_ramping", 32'(bus.ramping), 0);
        cyc();
        cyc();
        rst = 1'b0;
        pulse(1'b1, 1'b0, 1'b0);
        n = 0;
        while (bus.counter != 10'd999) begin
            cyc();
            n += int'(bus.pwm);
        end
        cyc();
        n += int'(bus.pwm);
        chk("post_rst_quiet", 32'(n), 0);
`ifdef FAN_SOFTSTART_EN
        chk("post_rst_duty", 32'(bus.duty), 50);
        count_period(n);
        chk("post_rst_highs", 32'(n), 50);
`else
        chk("post_rst_duty", 32'(bus.duty), 300);
        count_period(n);
        chk("post_rst_highs", 32'(n), 300);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
